natural_log: RTL and testbench

NATURAL_LOG -- requirements
Module: natural_log

---
 rtl/natural_log_pkg.sv | 28 ++
 rtl/natural_log_lzd32.sv | 19 +
 rtl/natural_log.sv | 142 ++++++++++++++
 tb/tb_natural_log.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/natural_log_pkg.sv
// Shared constants for natural_log: fixed-point widths, ln(2), the ln(1+2^-k)
// table and the FSM state type.
package natural_log_pkg;

   localparam int XW = 32;   // operand / result width (Q16.16)
   localparam int FW = 32;   // fraction bits of the Q0.32 log sum
   localparam int AW = 33;   // Q2.31 accumulator, 2 integer guard bits
   localparam int PW = 5;    // leading-one position width
   localparam int EW = 6;    // signed binary exponent width
   localparam int KW = 5;    // iteration index width
   localparam int SW = 40;   // signed width of e*LN2 + sum

   localparam logic [AW-1:0] ONE_Q231 = AW'(1) << 31;
   localparam logic [FW-1:0] LN2      = 32'hB172_17F8;

   // ln(1 + 2^-k) in Q0.32, k = 1..24
   localparam logic [FW-1:0] LN_TAB [1:24] = '{
      32'h67CC_8FB3, 32'h391F_EF8F, 32'h1E27_076E, 32'h0F85_1860,
      32'h07E0_A6C4, 32'h03F8_5156, 32'h01FE_02A7, 32'h00FF_8055,
      32'h007F_E00B, 32'h003F_F801, 32'h001F_FE00, 32'h000F_FF80,
      32'h0007_FFE0, 32'h0003_FFF8, 32'h0001_FFFE, 32'h0001_0000,
      32'h0000_8000, 32'h0000_4000, 32'h0000_2000, 32'h0000_1000,
      32'h0000_0800, 32'h0000_0400, 32'h0000_0200, 32'h0000_0100
   };

   typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

endpackage

// File: rtl/natural_log_lzd32.sv
// lzd32: combinational leading-one detector; p_o is the index of the highest
// set bit of x_i, zero_o flags an all-zero input.
module lzd32
   import natural_log_pkg::*;
(
   input  logic [XW-1:0] x_i,
   output logic [PW-1:0] p_o,
   output logic          zero_o
);

   always_comb begin
      p_o    = '0;
      zero_o = (x_i == '0);
      for (int i = 0; i < XW; i++) begin
         if (x_i[i]) p_o = PW'(i);
      end
   end

endmodule

// File: rtl/natural_log.sv
// natural_log: iterative shift-and-add ln(x), unsigned Q16.16 in, signed Q16.16 out.
// Define NATURAL_LOG_ROUND_EN for round-half-up reduction; default truncates toward -inf.
module natural_log
   import natural_log_pkg::*;
#(
   parameter int ITERS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        err
);

   state_t               state_q, state_d;
   logic [XW-1:0]        x_q, x_d;
   logic [XW-1:0]        m_q, m_d;
   logic [AW-1:0]        acc_q, acc_d;
   logic [FW-1:0]        sum_q, sum_d;
   logic [KW-1:0]        k_q, k_d;
   logic signed [EW-1:0] e_q, e_d;
   logic [XW-1:0]        y_q, y_d;
   logic                 err_q, err_d;
   logic                 vld_q, vld_d;
   logic [PW-1:0]        lead_p;
   logic                 lead_zero;
   logic [AW-1:0]        trial;

   lzd32 u_lzd (
      .x_i    (x_q),
      .p_o    (lead_p),
      .zero_o (lead_zero)
   );

   // y = e*ln2 + sum, then Q.32 -> Q16.16
   function automatic logic [XW-1:0] reduce_q16(input logic signed [EW-1:0] e,
                                                input logic [FW-1:0]        s);
      logic signed [SW-1:0] full;
      full = SW'(e) * $signed({{(SW-FW){1'b0}}, LN2})
           + $signed({{(SW-FW){1'b0}}, s});
`ifdef NATURAL_LOG_ROUND_EN
      full = full + (SW'(1) <<< 15);
`endif
      return XW'(full >>> 16);
   endfunction

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      m_d     = m_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      k_d     = k_q;
      e_d     = e_q;
      y_d     = y_q;
      err_d   = err_q;
      vld_d   = vld_q;
      trial   = acc_q + (acc_q >> k_q);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = x;
               state_d = NORM;
            end
         end
         NORM: begin
            if (lead_zero) begin
               y_d     = 32'h8000_0000;
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               e_d     = $signed({1'b0, lead_p}) - 6'sd16;
               m_d     = x_q << (5'd31 - lead_p);
               acc_d   = ONE_Q231;
               sum_d   = '0;
               k_d     = 5'd1;
               state_d = ITER;
            end
         end
         ITER: begin
            if (trial <= {1'b0, m_q}) begin
               acc_d = trial;
               sum_d = sum_q + LN_TAB[k_q];
            end
            k_d = k_q + 5'd1;
            if (k_q == KW'(ITERS)) begin
               y_d     = reduce_q16(e_q, sum_d);
               err_d   = 1'b0;
               vld_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // a zero operand arrives here one edge early; present it on the next
            if (!vld_q) begin
               vld_d = 1'b1;
            end else if (out_ready) begin
               vld_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vld_q   <= 1'b0;
         y_q     <= '0;
         err_q   <= 1'b0;
         acc_q   <= '0;
         sum_q   <= '0;
         k_q     <= '0;
         e_q     <= '0;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         y_q     <= y_d;
         err_q   <= err_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         k_q     <= k_d;
         e_q     <= e_d;
      end
   end

   always_ff @(posedge clk) begin
      x_q <= x_d;
      m_q <= m_d;
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = vld_q;
   assign y         = y_q;
   assign err       = err_q;

endmodule

// File: tb/tb_natural_log.sv
// Scoreboard bench for natural_log: driver pushes expected ln(x) from a real-valued
// model, an independent monitor pops and compares on each output handshake.
`timescale 1ns/1ps
module tb_natural_log;

   localparam int ITERS = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] x = '0;
   logic        in_ready, out_valid, err;
   logic [31:0] y;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] xv;
      real         exp_y;
      real         tol;
      int          acc_edge;
      int          lat;
      bit          zero;
   } txn_t;

   txn_t sb[$];

   natural_log #(.ITERS(ITERS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected normal completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input bit ok, input string act, input string req);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %s, expected %s", name, act, req);
      end
   endtask

   // Reference: true ln(x) scaled to Q16.16, independent of the hardware algorithm
   function automatic txn_t model(input logic [31:0] xv, input int acc_edge, input real tol);
      txn_t t;
      t.xv       = xv;
      t.acc_edge = acc_edge;
      t.zero     = (xv == 32'd0);
      t.lat      = t.zero ? 2 : ITERS + 1;
      t.exp_y    = t.zero ? 0.0 : $ln(real'(xv) / 65536.0) * 65536.0;
      t.tol      = tol;
      return t;
   endfunction

   initial begin : monitor
      bit          active;
      logic [31:0] y_hold;
      logic        err_hold;
      txn_t        t;
      real         diff;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
         end else if (out_valid) begin
            if (!active) begin
               active   = 1'b1;
               y_hold   = y;
               err_hold = err;
               if (sb.size() == 0)
                  check("unexpected_output", 1'b0, $sformatf("y=%h err=%0b", y, err), "no pending result");
               else
                  check("latency", (cyc - sb[0].acc_edge) == sb[0].lat,
                        $sformatf("%0d", cyc - sb[0].acc_edge), $sformatf("%0d", sb[0].lat));
            end else begin
               check("hold_stable", (y == y_hold) && (err == err_hold),
                     $sformatf("y=%h err=%0b", y, err), $sformatf("y=%h err=%0b", y_hold, err_hold));
            end
            check("in_ready_busy", in_ready == 1'b0, $sformatf("%0b", in_ready), "0");
            if (out_ready) begin
               active = 1'b0;
               if (sb.size() > 0) begin
                  t = sb.pop_front();
                  if (t.zero) begin
                     check("zero_y", y == 32'h8000_0000, $sformatf("%h", y), "80000000");
                     check("zero_err", err == 1'b1, $sformatf("%0b", err), "1");
                  end else begin
                     diff = real'($signed(y)) - t.exp_y;
                     check("ln_value", (diff <= t.tol) && (diff >= -t.tol),
                           $sformatf("x=%h y=%h (%0d)", t.xv, y, $signed(y)),
                           $sformatf("%f +/- %0.0f", t.exp_y, t.tol));
                     check("ln_err", err == 1'b0, $sformatf("%0b", err), "0");
                  end
               end
            end
         end
      end
   end

   task automatic send(input logic [31:0] xv, input real tol);
      bit ok;
      ok = 1'b0;
      @(posedge clk); #2;
      in_valid = 1'b1;
      x        = xv;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      check("accept", ok, $sformatf("in_ready=%0b", in_ready), "accept within 100 cycles");
      if (ok) sb.push_back(model(xv, cyc + 1, tol));
      @(posedge clk); #2;
      in_valid = 1'b0;
      x        = $urandom;
   endtask

   task automatic wait_done(input bit rand_ready);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #2;
         out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         n++;
      end
      check("completion", sb.size() == 0, $sformatf("%0d pending", sb.size()), "0 pending");
      @(posedge clk); #2;
      out_ready = 1'b1;
   endtask

   initial begin : driver
      logic [31:0] vec [6];
      real         tol [6];
      logic [31:0] xr;
      vec = '{32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      tol = '{1.0, 2.0, 2.0, 2.0, 2.0, 2.0};

      #12;
      check("reset_out_valid", out_valid == 1'b0, $sformatf("%0b", out_valid), "0");
      check("reset_y", y == 32'd0, $sformatf("%h", y), "00000000");
      check("reset_err", err == 1'b0, $sformatf("%0b", err), "0");
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      check("reset_in_ready", in_ready == 1'b1, $sformatf("%0b", in_ready), "1");

      for (int i = 0; i < 6; i++) begin
         send(vec[i], tol[i]);
         wait_done(1'b0);
      end

      // stall in DONE with a competing operand offered
      out_ready = 1'b0;
      send(32'h0005_0000, 2.0);
      for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
      repeat (10) begin
         @(posedge clk); #2;
         in_valid = 1'b1;
         x        = $urandom;
      end
      @(posedge clk); #2;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      wait_done(1'b0);
      repeat (30) @(posedge clk);
      #2;
      check("ignored_operand", in_ready == 1'b1 && out_valid == 1'b0,
            $sformatf("in_ready=%0b out_valid=%0b", in_ready, out_valid), "in_ready=1 out_valid=0");

      // leave a nonzero y/err held, then abort a computation with reset
      send(32'h0000_0000, 2.0);
      wait_done(1'b0);
      send(32'h0003_0000, 2.0);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("abort_out_valid", out_valid == 1'b0, $sformatf("%0b", out_valid), "0");
      check("abort_y", y == 32'd0, $sformatf("%h", y), "00000000");
      check("abort_err", err == 1'b0, $sformatf("%0b", err), "0");
      @(posedge clk); #2;
      rst_n = 1'b1;
      #1;
      check("abort_in_ready", in_ready == 1'b1, $sformatf("%0b", in_ready), "1");
      send(32'h0002_0000, 2.0);
      wait_done(1'b0);

      for (int i = 0; i < 40; i++) begin
         xr = $urandom >> $urandom_range(0, 31);
         send(xr, 2.0);
         wait_done(1'b1);
      end

      repeat (30) @(posedge clk);
      check("scoreboard_empty", sb.size() == 0, $sformatf("%0d", sb.size()), "0");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
